// File: rtl/dm_arb_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Port indices, lock-state encoding and a saturating counter helper.
package dm_arb_pkg;

  localparam int DM_AW       = 10;
  localparam int DM_DW       = 32;
  localparam int DM_MAX_LOCK = 8;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_AUX = 1'b1
  } port_e;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dm_arb_rr2.sv
// Two-way round-robin pick with the last-winner register.
// On contention the port that did not win last time is picked.
module dm_arb_rr2
  import dm_arb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  req_cpu,
  input  logic  req_aux,
  input  logic  upd,
  input  port_e win,
  output port_e pick
);

  port_e last_win;

  // Resetting to aux makes the cpu the favoured port on the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_win <= PORT_AUX;
    end else if (upd) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      last_win <= win;
    end
  end

  always_comb begin
    if (req_cpu && req_aux) begin
      pick = (last_win == PORT_CPU) ? PORT_AUX : PORT_CPU;
    end else if (req_aux) begin
      pick = PORT_AUX;
    end else begin
      pick = PORT_CPU;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage and an aux master.
// Optional statistics counters are enabled with `define DM_ARB_STATS_EN.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW       = DM_AW,
  parameter int DW       = DM_DW,
  parameter int MAX_LOCK = DM_MAX_LOCK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  input  logic          aux_lock,
  output logic          aux_gnt,
  output logic [DW-1:0] aux_rdata,
  output logic          aux_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_dout
`ifdef DM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_cpu_acc,
  output logic [31:0]   stat_aux_acc,
  output logic [31:0]   stat_cpu_stall
`endif
);

  localparam logic [7:0] CAP = 8'(MAX_LOCK);

  lock_state_e state, state_nxt;
  logic [7:0]  lock_cnt, lock_cnt_nxt;
  logic        force_cpu, force_nxt;
  port_e       rr_pick, win;

  dm_arb_rr2 u_rr2 (
    .clk     (clk),
    .rst     (rst),
    .req_cpu (cpu_req),
    .req_aux (aux_req),
    .upd     (cpu_gnt | aux_gnt),
    .win     (win),
    .pick    (rr_pick)
  );

  // Lock and forced release only override the round-robin on contention.
  always_comb begin
    win = rr_pick;
    if (cpu_req && aux_req) begin
      if (force_cpu) begin
        win = PORT_CPU;
      end else if (state == LK_LOCKED && aux_lock) begin
        win = PORT_AUX;
      end
    end
  end

  assign cpu_gnt   = cpu_req && (win == PORT_CPU);
  assign aux_gnt   = aux_req && (win == PORT_AUX);
  assign cpu_stall = cpu_req && !cpu_gnt;
  assign mem_addr  = aux_gnt ? aux_addr  : cpu_addr;
  assign mem_din   = aux_gnt ? aux_wdata : cpu_wdata;
  assign mem_wr    = !rst && ((cpu_gnt && cpu_we) || (aux_gnt && aux_we));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    force_nxt    = 1'b0;
    case (state)
      LK_UNLOCKED: begin
        if (aux_gnt && aux_lock) begin
          if (CAP == 8'd1) begin
            force_nxt = 1'b1;
          end else begin
            state_nxt    = LK_LOCKED;
            lock_cnt_nxt = 8'd1;
          end
        end
      end
      LK_LOCKED: begin
        if (!aux_lock || !aux_req) begin
          state_nxt    = LK_UNLOCKED;
          lock_cnt_nxt = 8'd0;
        end else if (aux_gnt) begin
          if (lock_cnt + 8'd1 == CAP) begin
            state_nxt    = LK_UNLOCKED;
            lock_cnt_nxt = 8'd0;
            force_nxt    = 1'b1;
          end else begin
            lock_cnt_nxt = lock_cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nxt    = LK_UNLOCKED;
        lock_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LK_UNLOCKED;
      lock_cnt   <= 8'd0;
      force_cpu  <= 1'b0;
      cpu_rvalid <= 1'b0;
      aux_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      aux_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      lock_cnt   <= lock_cnt_nxt;
      force_cpu  <= force_nxt;
      cpu_rvalid <= cpu_gnt && !cpu_we;
      aux_rvalid <= aux_gnt && !aux_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= mem_dout;
      if (aux_gnt && !aux_we) aux_rdata <= mem_dout;
    end
  end

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cpu_acc   <= '0;
      stat_aux_acc   <= '0;
      stat_cpu_stall <= '0;
    end else begin
      if (cpu_gnt)   stat_cpu_acc   <= sat_inc(stat_cpu_acc);
      if (aux_gnt)   stat_aux_acc   <= sat_inc(stat_aux_acc);
      if (cpu_stall) stat_cpu_stall <= sat_inc(stat_cpu_stall);
    end
  end
`endif

endmodule
